bp_nonsynth_io_responder: RTL and testbench

//  Target (responder) end of the BlackParrot uncached I/O command/response link. Consumes
//  io_cmd messages from an initiator (NBF loader, CCE cfg loader, host link), executes

---
 rtl/bp_me_pkg.sv | 67 ++++++
 rtl/bp_io_responder_regbank.sv | 37 +++
 rtl/bp_nonsynth_io_responder.sv | 175 +++++++++++++++++
 tb/tb_bp_nonsynth_io_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the uncached I/O responder: command type
// encoding, responder FSM states, the bank ID constant and the byte-lane
// helper functions used by the decode and register bank.
package bp_me_pkg;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'b0000,
        e_mem_msg_wr    = 4'b0001,
        e_mem_msg_uc_rd = 4'b0010,
        e_mem_msg_uc_wr = 4'b0011,
        e_mem_msg_pre   = 4'b0100,
        e_mem_msg_amo   = 4'b0101
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [1:0] {
        e_io_rsp_idle,
        e_io_rsp_wait,
        e_io_rsp_resp
    } bp_io_responder_state_e;

    // Upper bits of the read-only ID register; the bank size is XORed in
    localparam logic [63:0] bp_io_responder_id_gp = 64'h0000_0000_B1AC_0000;

    // Reset value of register 0 for a bank of num_regs entries
    function automatic logic [63:0] io_reset_id(input int num_regs);
        return bp_io_responder_id_gp ^ 64'(num_regs);
    endfunction

    // Byte lanes covered by an access of 2**size bytes at offset 0
    function automatic logic [7:0] io_size_byte_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Offset bits that must be zero for an access of 2**size bytes
    function automatic logic [2:0] io_align_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Expand a per-byte enable into a per-bit enable
    function automatic logic [63:0] io_byte_to_bit_mask(input logic [7:0] byte_mask);
        logic [63:0] bit_mask;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
        return bit_mask;
    endfunction

    // Right-align the addressed bytes of a register and zero the rest
    function automatic logic [63:0] io_read_extract(input logic [63:0] word,
                                                    input logic [2:0]  offset,
                                                    input logic [1:0]  size);
        logic [63:0] shifted;
        shifted = word >> {offset, 3'b000};
        return shifted & io_byte_to_bit_mask(io_size_byte_mask(size));
    endfunction

endpackage

// File: rtl/bp_io_responder_regbank.sv
// Bank of 64-bit registers behind the I/O responder. Register 0 holds the
// bank ID at reset; the rest clear to zero. One byte-masked write port and
// one combinational read port.
module bp_io_responder_regbank
    import bp_me_pkg::*;
#(
    parameter int num_regs_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          w_v_i,
    input  logic [$clog2(num_regs_p)-1:0] w_idx_i,
    input  logic [7:0]                    w_byte_mask_i,
    input  logic [63:0]                   w_data_i,
    input  logic [$clog2(num_regs_p)-1:0] r_idx_i,
    output logic [63:0]                   r_data_o
);

    logic [63:0] regs_r [num_regs_p];
    logic [63:0] w_bit_mask;

    assign w_bit_mask = io_byte_to_bit_mask(w_byte_mask_i);

    // Register storage: ID/zero on reset, merge write data under the byte mask
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_regs_p; i++) begin
                regs_r[i] <= (i == 0) ? io_reset_id(num_regs_p) : 64'd0;
            end
        end else if (w_v_i) begin
            regs_r[w_idx_i] <= (regs_r[w_idx_i] & ~w_bit_mask) | (w_data_i & w_bit_mask);
        end
    end

    assign r_data_o = regs_r[r_idx_i];

endmodule

// File: rtl/bp_nonsynth_io_responder.sv
// Responder end of the uncached I/O cmd/resp link. Accepts one command at a
// time, waits latency_p cycles, performs the register access and holds the
// response until the initiator takes it.
module bp_nonsynth_io_responder
    import bp_me_pkg::*;
#(
    parameter int                         paddr_width_p   = 40,
    parameter int                         data_width_p    = 64,
    parameter int                         payload_width_p = 16,
    parameter int                         num_regs_p      = 16,
    parameter logic [paddr_width_p-1:0]   base_addr_p     = 'h20_0000,
    parameter int                         latency_p       = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [3:0]                 io_cmd_type_i,
    input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
    input  logic [2:0]                 io_cmd_size_i,
    input  logic [payload_width_p-1:0] io_cmd_payload_i,
    input  logic [data_width_p-1:0]    io_cmd_data_i,
    input  logic                       io_cmd_v_i,
    output logic                       io_cmd_yumi_o,

    output logic [3:0]                 io_resp_type_o,
    output logic [paddr_width_p-1:0]   io_resp_addr_o,
    output logic [2:0]                 io_resp_size_o,
    output logic [payload_width_p-1:0] io_resp_payload_o,
    output logic [data_width_p-1:0]    io_resp_data_o,
    output logic                       io_resp_err_o,
    output logic                       io_resp_v_o,
    input  logic                       io_resp_ready_i
);

    localparam int idx_w = $clog2(num_regs_p);
    localparam int cnt_w = (latency_p > 1) ? $clog2(latency_p) : 1;

    bp_io_responder_state_e state_r;
    logic [cnt_w-1:0]           cnt_r;

    // Latched command
    logic [3:0]                 cmd_type_r;
    logic [paddr_width_p-1:0]   cmd_addr_r;
    logic [2:0]                 cmd_size_r;
    logic [payload_width_p-1:0] cmd_payload_r;
    logic [data_width_p-1:0]    cmd_data_r;

    // Registered response
    logic [3:0]                 resp_type_r;
    logic [paddr_width_p-1:0]   resp_addr_r;
    logic [2:0]                 resp_size_r;
    logic [payload_width_p-1:0] resp_payload_r;
    logic [data_width_p-1:0]    resp_data_r;
    logic                       resp_err_r;
    logic                       resp_v_r;

    // Decode of the latched command
    logic [paddr_width_p-1:0]   rel_addr;
    logic                       hit;
    logic                       size_ok;
    logic                       aligned;
    logic                       is_rd;
    logic                       is_wr;
    logic                       acc_err;
    logic                       access;
    logic [2:0]                 offset;
    logic [idx_w-1:0]           idx;
    logic [7:0]                 wr_byte_mask;
    logic [63:0]                wr_data_shifted;
    logic [63:0]                rd_word;
    logic [63:0]                rd_data;

    // Commands are only taken in IDLE, and never while reset is asserted
    assign io_cmd_yumi_o = reset_n_i & io_cmd_v_i & (state_r == e_io_rsp_idle);

    // Address decode, alignment/type checks and byte-lane steering
    always_comb begin
        rel_addr        = cmd_addr_r - base_addr_p;
        hit             = (cmd_addr_r >= base_addr_p)
                          && ((rel_addr >> 3) < paddr_width_p'(num_regs_p));
        offset          = cmd_addr_r[2:0];
        idx             = rel_addr[idx_w+2:3];
        size_ok         = (cmd_size_r <= 3'd3);
        aligned         = ((offset & io_align_mask(cmd_size_r[1:0])) == 3'd0);
        is_rd           = (cmd_type_r == e_mem_msg_uc_rd);
        is_wr           = (cmd_type_r == e_mem_msg_uc_wr);
        // Register 0 is the read-only ID; writing it is a fault
        acc_err         = !hit || !size_ok || !aligned || !(is_rd || is_wr)
                          || (is_wr && (idx == '0));
        access          = (state_r == e_io_rsp_wait) && (cnt_r == '0);
        wr_byte_mask    = io_size_byte_mask(cmd_size_r[1:0]) << offset;
        wr_data_shifted = cmd_data_r << {offset, 3'b000};
        rd_data         = io_read_extract(rd_word, offset, cmd_size_r[1:0]);
    end

    bp_io_responder_regbank #(
        .num_regs_p (num_regs_p)
    ) regbank (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .w_v_i         (access && is_wr && !acc_err),
        .w_idx_i       (idx),
        .w_byte_mask_i (wr_byte_mask),
        .w_data_i      (wr_data_shifted),
        .r_idx_i       (idx),
        .r_data_o      (rd_word)
    );

    // Responder FSM: latch cmd, count down the latency, then hold the response
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r        <= e_io_rsp_idle;
            cnt_r          <= '0;
            cmd_type_r     <= '0;
            cmd_addr_r     <= '0;
            cmd_size_r     <= '0;
            cmd_payload_r  <= '0;
            cmd_data_r     <= '0;
            resp_type_r    <= '0;
            resp_addr_r    <= '0;
            resp_size_r    <= '0;
            resp_payload_r <= '0;
            resp_data_r    <= '0;
            resp_err_r     <= 1'b0;
            resp_v_r       <= 1'b0;
        end else begin
            case (state_r)
                e_io_rsp_idle: begin
                    if (io_cmd_yumi_o) begin
                        cmd_type_r    <= io_cmd_type_i;
                        cmd_addr_r    <= io_cmd_addr_i;
                        cmd_size_r    <= io_cmd_size_i;
                        cmd_payload_r <= io_cmd_payload_i;
                        cmd_data_r    <= io_cmd_data_i;
                        cnt_r         <= cnt_w'(latency_p - 1);
                        state_r       <= e_io_rsp_wait;
                    end
                end
                e_io_rsp_wait: begin
                    if (cnt_r == '0) begin
                        resp_type_r    <= cmd_type_r;
                        resp_addr_r    <= cmd_addr_r;
                        resp_size_r    <= cmd_size_r;
                        resp_payload_r <= cmd_payload_r;
                        resp_data_r    <= (is_rd && !acc_err) ? rd_data : '0;
                        resp_err_r     <= acc_err;
                        resp_v_r       <= 1'b1;
                        state_r        <= e_io_rsp_resp;
                    end else begin
                        cnt_r <= cnt_r - cnt_w'(1);
                    end
                end
                e_io_rsp_resp: begin
                    if (io_resp_ready_i) begin
                        resp_v_r <= 1'b0;
                        state_r  <= e_io_rsp_idle;
                    end
                end
                default: begin
                    resp_v_r <= 1'b0;
                    state_r  <= e_io_rsp_idle;
                end
            endcase
        end
    end

    assign io_resp_type_o    = resp_type_r;
    assign io_resp_addr_o    = resp_addr_r;
    assign io_resp_size_o    = resp_size_r;
    assign io_resp_payload_o = resp_payload_r;
    assign io_resp_data_o    = resp_data_r;
    assign io_resp_err_o     = resp_err_r;
    assign io_resp_v_o       = resp_v_r;

endmodule

// File: tb/tb_bp_nonsynth_io_responder.sv
// Scoreboard bench for bp_nonsynth_io_responder: the driver pushes the
// hand-computed response of every accepted command, the monitor pops and
// compares whenever a response handshake occurs.
module tb_bp_nonsynth_io_responder;

    localparam int          LAT  = 2;
    localparam int          NREG = 16;
    localparam logic [39:0] BASE = 40'h20_0000;
    localparam logic [63:0] ID   = 64'h0000_0000_B1AC_0010;
    localparam logic [3:0]  T_RD    = 4'd0;
    localparam logic [3:0]  T_UC_RD = 4'd2;
    localparam logic [3:0]  T_UC_WR = 4'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cmd_type = '0;
    logic [39:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [15:0] cmd_payload = '0;
    logic [63:0] cmd_data = '0;
    logic        cmd_v = 1'b0;
    logic        yumi;
    logic [3:0]  resp_type;
    logic [39:0] resp_addr;
    logic [2:0]  resp_size;
    logic [15:0] resp_payload;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        resp_v;
    logic        resp_ready = 1'b1;

    typedef struct {
        string       tag;
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [15:0] pl;
        logic [63:0] data;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pl_cnt = 0;

    bp_nonsynth_io_responder #(
        .paddr_width_p   (40),
        .data_width_p    (64),
        .payload_width_p (16),
        .num_regs_p      (NREG),
        .base_addr_p     (BASE),
        .latency_p       (LAT)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (rst_n),
        .io_cmd_type_i     (cmd_type),
        .io_cmd_addr_i     (cmd_addr),
        .io_cmd_size_i     (cmd_size),
        .io_cmd_payload_i  (cmd_payload),
        .io_cmd_data_i     (cmd_data),
        .io_cmd_v_i        (cmd_v),
        .io_cmd_yumi_o     (yumi),
        .io_resp_type_o    (resp_type),
        .io_resp_addr_o    (resp_addr),
        .io_resp_size_o    (resp_size),
        .io_resp_payload_o (resp_payload),
        .io_resp_data_o    (resp_data),
        .io_resp_err_o     (resp_err),
        .io_resp_v_o       (resp_v),
        .io_resp_ready_i   (resp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency, stability while stalled, yumi blocking, and in-order compare
    logic        in_resp = 1'b0;
    logic [127:0] held;
    logic [127:0] cur;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp = 1'b0;
        end else if (resp_v) begin
            cur = {resp_type, resp_addr, resp_size, resp_payload, resp_data, resp_err};
            if (cmd_v) chk("yumi_during_resp", 128'(yumi), 128'(0));
            if (!in_resp) begin
                in_resp = 1'b1;
                held    = cur;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: got %h, expected no response", cur);
                end else begin
                    chk({sb[0].tag, "_latency"}, 128'(cyc - sb[0].acc_cyc), 128'(LAT + 1));
                end
            end else begin
                chk("resp_stable", cur, held);
            end
            if (resp_ready) begin
                in_resp = 1'b0;
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk(mon_e.tag, cur, {mon_e.typ, mon_e.addr, mon_e.size, mon_e.pl,
                                         mon_e.data, mon_e.err});
                end
            end
        end
    end

    task automatic issue(input string tag, input logic [3:0] typ, input logic [39:0] addr,
                         input logic [2:0] size, input logic [63:0] data,
                         input logic [63:0] exp_data, input logic exp_err);
        exp_t e;
        int   n;
        logic [15:0] pl;
        pl = 16'hC000 + 16'(pl_cnt);
        pl_cnt++;
        @(posedge clk);
        #1;
        cmd_type    = typ;
        cmd_addr    = addr;
        cmd_size    = size;
        cmd_payload = pl;
        cmd_data    = data;
        cmd_v       = 1'b1;
        n = 0;
        @(negedge clk);
        while (!yumi && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!yumi) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_accept: got no yumi, expected yumi within 300 cycles", tag);
            cmd_v = 1'b0;
            return;
        end
        e.tag = tag; e.typ = typ; e.addr = addr; e.size = size; e.pl = pl;
        e.data = exp_data; e.err = exp_err; e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || resp_v) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        // Reset state, with cmd_v asserted to show yumi is held off
        cmd_v = 1'b1;
        #12;
        chk("rst_yumi", 128'(yumi), 128'(0));
        chk("rst_resp_v", 128'(resp_v), 128'(0));
        chk("rst_resp_data", 128'(resp_data), 128'(0));
        chk("rst_resp_err", 128'(resp_err), 128'(0));
        cmd_v = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 1: ID register
        issue("t1_id", T_UC_RD, BASE, 3'd3, 64'd0, ID, 1'b0);
        // 2: full write/read
        issue("t2_wr", T_UC_WR, BASE + 40'd8, 3'd3, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0);
        issue("t2_rd", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0);
        // 3: byte write into byte 5, then wide and narrow reads
        issue("t3_wrb", T_UC_WR, BASE + 40'd13, 3'd0, 64'h0000_0000_0000_00A5, 64'd0, 1'b0);
        issue("t3_rd8", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'hDEAD_A5EF_0123_4567, 1'b0);
        issue("t3_rd4", T_UC_RD, BASE + 40'd12, 3'd2, 64'd0, 64'h0000_0000_DEAD_A5EF, 1'b0);
        issue("t3_rd2", T_UC_RD, BASE + 40'd14, 3'd1, 64'd0, 64'h0000_0000_0000_DEAD, 1'b0);
        issue("t3_rd1", T_UC_RD, BASE + 40'd13, 3'd0, 64'd0, 64'h0000_0000_0000_00A5, 1'b0);
        // Half-word write ignores data above its size
        issue("t3_wrh", T_UC_WR, BASE + 40'd16, 3'd1, 64'h0000_0000_FFFF_1234, 64'd0, 1'b0);
        issue("t3_rdh", T_UC_RD, BASE + 40'd16, 3'd3, 64'd0, 64'h0000_0000_0000_1234, 1'b0);
        // 4: faults
        issue("t4_misal", T_UC_RD, BASE + 40'd10, 3'd2, 64'd0, 64'd0, 1'b1);
        issue("t4_wr_miss", T_UC_WR, BASE + 40'd128, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        issue("t4_rd_below", T_UC_RD, BASE - 40'd8, 3'd3, 64'd0, 64'd0, 1'b1);
        issue("t4_wr_misal", T_UC_WR, BASE + 40'd9, 3'd1, 64'hFFFF, 64'd0, 1'b1);
        issue("t4_size4", T_UC_RD, BASE + 40'd8, 3'd4, 64'd0, 64'd0, 1'b1);
        issue("t4_badtype", T_RD, BASE + 40'd8, 3'd3, 64'd0, 64'd0, 1'b1);
        issue("t4_wr_id", T_UC_WR, BASE, 3'd3, 64'h1111_2222_3333_4444, 64'd0, 1'b1);
        issue("t4_rd_id", T_UC_RD, BASE, 3'd3, 64'd0, ID, 1'b0);
        issue("t4_rd_last", T_UC_RD, BASE + 40'd120, 3'd3, 64'd0, 64'd0, 1'b0);
        issue("t4_rd_keep", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'hDEAD_A5EF_0123_4567, 1'b0);
        drain("t4");

        // 5: stall the response with a second command waiting
        resp_ready = 1'b0;
        issue("t5_a", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'hDEAD_A5EF_0123_4567, 1'b0);
        fork
            issue("t5_b", T_UC_RD, BASE + 40'd16, 3'd1, 64'd0, 64'h0000_0000_0000_1234, 1'b0);
            begin
                repeat (LAT + 10) @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        drain("t5");

        // 6: reset while the command is in WAIT
        issue("t6_lost", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'hDEAD_A5EF_0123_4567, 1'b0);
        rst_n = 1'b0;
        cmd_v = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_resp_v", 128'(resp_v), 128'(0));
        chk("t6_rst_yumi", 128'(yumi), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_yumi_hold", 128'(yumi), 128'(0));
        cmd_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        issue("t6_rd1", T_UC_RD, BASE + 40'd8, 3'd3, 64'd0, 64'd0, 1'b0);
        issue("t6_rd2", T_UC_RD, BASE + 40'd16, 3'd3, 64'd0, 64'd0, 1'b0);
        issue("t6_rd_id", T_UC_RD, BASE, 3'd3, 64'd0, ID, 1'b0);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
